// File: rtl/vca.sv
// rtl/vca.sv - envelope-controlled amplifier: offset-binary sample scaled by 8-bit gain
// Sequential shift-add multiply, one sample in flight, late strobes dropped and flagged.
module vca (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic [7:0] envelope,
  output logic [7:0] sample_out,
  output logic       out_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        iterate;
  logic        finish;

  logic        neg;
  logic [7:0]  mag;
  logic [7:0]  env;
  logic [15:0] acc;
  logic [2:0]  cnt;

  logic [7:0]  d;
  logic [7:0]  m_in;
  logic [15:0] addend;
  logic [7:0]  q;
  logic [7:0]  result;

  // 0x80 (-128) negates to itself, which read unsigned is the magnitude 128.
  assign d      = sample_in ^ 8'h80;
  assign m_in   = d[7] ? (~d + 8'd1) : d;
  assign addend = {8'd0, mag} << cnt;
  assign q      = acc[15:8];
  assign result = (neg ? (~q + 8'd1) : q) ^ 8'h80;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          accept     = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        iterate = 1'b1;
        if (cnt == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator starts at m so the final product is m * (envelope + 1).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      neg        <= 1'b0;
      mag        <= 8'd0;
      env        <= 8'd0;
      acc        <= 16'd0;
      cnt        <= 3'd0;
      sample_out <= 8'h80;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= finish;
      overrun   <= sample_valid && (state != IDLE);
      if (accept) begin
        neg <= d[7];
        mag <= m_in;
        env <= envelope;
        acc <= {8'd0, m_in};
        cnt <= 3'd0;
      end
      if (iterate) begin
        if (env[cnt]) begin
          acc <= acc + addend;
        end
        cnt <= cnt + 3'd1;
      end
      if (finish) begin
        sample_out <= result;
      end
    end
  end

endmodule

// File: tb/tb_vca.sv
// tb/tb_vca.sv - directed and model-based checks of vca latency, arithmetic, overrun and reset
module tb_vca;

  logic       clk;
  logic       rstn;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] envelope;
  logic [7:0] sample_out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  int n_checks;
  int n_pass;
  int n_fail;

  vca dut (
    .clk          (clk),
    .rstn         (rstn),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .envelope     (envelope),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_vca(input logic [7:0] s, input logic [7:0] e);
    int d;
    int m;
    int q;
    d = int'($signed(s ^ 8'h80));
    m = (d < 0) ? -d : d;
    q = (m * (int'(e) + 1)) >>> 8;
    if (d < 0) q = -q;
    return 8'(q) ^ 8'h80;
  endfunction

  // Strobe in the current cycle T; returns in cycle T+10 with the result checked.
  task automatic run(input string tag, input logic [7:0] s, input logic [7:0] e,
                     input logic [7:0] exp);
    logic early;
    logic ovr;
    check({tag, "_idle"}, busy, 1'b0);
    sample_in    = s;
    envelope     = e;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    sample_in    = $urandom;
    envelope     = $urandom;
    check({tag, "_busy"}, busy, 1'b1);
    early = out_valid;
    ovr   = overrun;
    for (int i = 0; i < 8; i++) begin
      step();
      early = early | out_valid;
      ovr   = ovr | overrun;
    end
    check({tag, "_early"}, early, 1'b0);
    step();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_done"}, busy, 1'b0);
    check({tag, "_ovr"}, ovr | overrun, 1'b0);
    check({tag, "_out"}, sample_out, exp);
  endtask

  initial begin
    logic seen;
    logic [7:0] rs;
    logic [7:0] re;
    n_checks     = 0;
    n_pass       = 0;
    n_fail       = 0;
    rstn         = 1'b0;
    sample_valid = 1'b1;
    sample_in    = $urandom;
    envelope     = $urandom;

    step();
    sample_in = $urandom;
    envelope  = $urandom;
    step();
    check("rst_out", sample_out, 8'h80);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", overrun, 1'b0);

    rstn         = 1'b1;
    sample_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | out_valid | busy;
    end
    check("idle_quiet", seen, 1'b0);

    run("unity_ff", 8'hFF, 8'hFF, 8'hFF);
    run("unity_00", 8'h00, 8'hFF, 8'h00);
    run("mute_00", 8'h00, 8'h00, 8'h80);
    run("mute_c0", 8'hC0, 8'h00, 8'h80);
    run("half_ff", 8'hFF, 8'h80, 8'hBF);
    run("half_01", 8'h01, 8'h80, 8'h41);
    run("half_00", 8'h00, 8'h80, 8'h40);

    // Latch and overrun: 127*65 >> 8 = 32 -> 0xA0.
    sample_in    = 8'hFF;
    envelope     = 8'h40;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    envelope     = 8'hFF;
    step();
    step();
    check("lat_ovr_t3", overrun, 1'b0);
    sample_in    = 8'h00;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("lat_ovr_t4", overrun, 1'b1);
    step();
    check("lat_ovr_t5", overrun, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | out_valid | overrun;
    end
    check("lat_quiet", seen, 1'b0);
    step();
    check("lat_valid", out_valid, 1'b1);
    check("lat_out", sample_out, 8'hA0);
    step();
    check("lat_single", out_valid, 1'b0);
    check("lat_busy", busy, 1'b0);

    // Reset in T+5 aborts the multiply.
    sample_in    = 8'hFF;
    envelope     = 8'hFF;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("mid_busy", busy, 1'b0);
    check("mid_out", sample_out, 8'h80);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | out_valid | busy;
    end
    check("mid_quiet", seen, 1'b0);
    run("mid_after", 8'h01, 8'hFF, 8'h01);

    // Back-to-back sweep: every sample for several gains, then random pairs.
    for (int e = 0; e < 6; e++) begin
      case (e)
        0: re = 8'h00;
        1: re = 8'h01;
        2: re = 8'h7F;
        3: re = 8'h80;
        4: re = 8'hFE;
        default: re = 8'hFF;
      endcase
      for (int s = 0; s < 256; s++) begin
        rs = 8'(s);
        run("sweep", rs, re, ref_vca(rs, re));
      end
    end
    for (int i = 0; i < 1000; i++) begin
      rs = 8'($urandom);
      re = 8'($urandom);
      run("rand", rs, re, ref_vca(rs, re));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
